// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back end of the operand-forwarding path. Holds the W pipeline
//   register, retires W results into the 15 x 64-bit Y86 register file,
//   provides the two decode-stage read ports, the program status and a
//   count of retired instructions.
//
// Ports
//   clk_i, rst_n_i             clock (rising edge), async active-low reset
//   W_stall_i, W_bubble_i      W register control (stall beats bubble)
//   m_stat_i, M_icode_i,
//   M_valid_i, M_valE_i,
//   m_valM_i, M_dstE_i,
//   M_dstM_i                   M-stage result loaded into W
//   d_srcA_i, d_srcB_i         decode read port register ids
//   d_rvalA_o, d_rvalB_o       register file read data (0 for RNONE)
//   W_icode_o, W_valE_o,
//   W_valM_o, W_dstE_o,
//   W_dstM_o                   W register contents (forwarding sources)
//   stat_o                     program status (W stat)
//   retired_o                  retired instruction count, wraps
//
// Handshake: none. W follows the pipeline control each rising edge:
// stall holds, bubble loads a NOP, otherwise the M stage is captured.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module wb_regfile #(
  parameter int NREG  = 15,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             W_stall_i,
  input  logic             W_bubble_i,
  input  logic [3:0]       m_stat_i,
  input  logic [3:0]       M_icode_i,
  input  logic             M_valid_i,
  input  logic [63:0]      M_valE_i,
  input  logic [63:0]      m_valM_i,
  input  logic [3:0]       M_dstE_i,
  input  logic [3:0]       M_dstM_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  output logic [63:0]      d_rvalA_o,
  output logic [63:0]      d_rvalB_o,
  output logic [3:0]       W_icode_o,
  output logic [63:0]      W_valE_o,
  output logic [63:0]      W_valM_o,
  output logic [3:0]       W_dstE_o,
  output logic [3:0]       W_dstM_o,
  output logic [3:0]       stat_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] SAOK  = 4'h1;
  localparam logic [3:0] SHLT  = 4'h2;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  stat;
    logic        valid;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    icode: INOP,
    stat:  SAOK,
    valid: 1'b0,
    val_e: 64'd0,
    val_m: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  w_reg_t            w_reg;
  w_reg_t            w_next;
  logic [63:0]       regs [NREG];
  logic              wb_en;
  logic              retire;
  logic [CNT_W-1:0]  retired_q;

  // ---------------------------------------------------------------------------
  // W pipeline register
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = w_reg;
    if (!W_stall_i) begin
      if (W_bubble_i) begin
        w_next = W_BUBBLE;
      end else begin
        w_next.icode = M_icode_i;
        w_next.stat  = m_stat_i;
        w_next.valid = M_valid_i;
        w_next.val_e = M_valE_i;
        w_next.val_m = m_valM_i;
        w_next.dst_e = M_dstE_i;
        w_next.dst_m = M_dstM_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_reg <= W_BUBBLE;
    end else begin
      w_reg <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back from the current W contents. A stalled W carries a non-AOK
  // status, so ignoring the stall here never writes a faulting instruction.
  // ---------------------------------------------------------------------------
  assign wb_en  = w_reg.valid && (w_reg.stat == SAOK);
  assign retire = wb_en || (w_reg.valid && (w_reg.stat == SHLT));

  // valM is checked first so it wins when dstE == dstM (popq %rsp).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= 64'd0;
      end
    end else if (wb_en) begin
      for (int i = 0; i < NREG; i++) begin
        if (w_reg.dst_m == 4'(i)) begin
          regs[i] <= w_reg.val_m;
        end else if (w_reg.dst_e == 4'(i)) begin
          regs[i] <= w_reg.val_e;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: straight from the array. RNONE matches no entry and reads 0.
  // No write->read bypass; the decode forwarding mux covers W.
  // ---------------------------------------------------------------------------
  always_comb begin
    d_rvalA_o = 64'd0;
    d_rvalB_o = 64'd0;
    for (int i = 0; i < NREG; i++) begin
      if (d_srcA_i == 4'(i)) begin
        d_rvalA_o = regs[i];
      end
      if (d_srcB_i == 4'(i)) begin
        d_rvalB_o = regs[i];
      end
    end
  end

  assign W_icode_o = w_reg.icode;
  assign W_valE_o  = w_reg.val_e;
  assign W_valM_o  = w_reg.val_m;
  assign W_dstE_o  = w_reg.dst_e;
  assign W_dstM_o  = w_reg.dst_m;
  assign stat_o    = w_reg.stat;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile. Directed scenario tasks plus a
//   randomized run, all checked against a behavioural model of the
//   architectural state (W register, register array, retire count).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wb_regfile;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] IOPQ  = 4'h6;
  localparam logic [3:0] IPOPQ = 4'hB;
  localparam logic [3:0] SAOK  = 4'h1;
  localparam logic [3:0] SHLT  = 4'h2;
  localparam logic [3:0] SADR  = 4'h3;
  localparam logic [3:0] SINS  = 4'h4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        stall, bubble;
  logic [3:0]  m_stat, m_icode;
  logic        m_valid;
  logic [63:0] m_vale, m_valm;
  logic [3:0]  m_dste, m_dstm;
  logic [3:0]  src_a, src_b;
  logic [63:0] rval_a, rval_b;
  logic [3:0]  w_icode, w_dste, w_dstm, stat;
  logic [63:0] w_vale, w_valm, retired;

  wb_regfile dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .W_stall_i  (stall),
    .W_bubble_i (bubble),
    .m_stat_i   (m_stat),
    .M_icode_i  (m_icode),
    .M_valid_i  (m_valid),
    .M_valE_i   (m_vale),
    .m_valM_i   (m_valm),
    .M_dstE_i   (m_dste),
    .M_dstM_i   (m_dstm),
    .d_srcA_i   (src_a),
    .d_srcB_i   (src_b),
    .d_rvalA_o  (rval_a),
    .d_rvalB_o  (rval_b),
    .W_icode_o  (w_icode),
    .W_valE_o   (w_vale),
    .W_valM_o   (w_valm),
    .W_dstE_o   (w_dste),
    .W_dstM_o   (w_dstm),
    .stat_o     (stat),
    .retired_o  (retired)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // Reference model: architectural state advanced once per clock edge
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  stat;
    logic        valid;
    logic [63:0] ve;
    logic [63:0] vm;
    logic [3:0]  de;
    logic [3:0]  dm;
  } w_t;

  w_t          mw;
  logic [63:0] mregs [0:14];
  logic [63:0] mret;

  function automatic void model_reset();
    mw = '{icode: INOP, stat: SAOK, valid: 1'b0, ve: 64'd0, vm: 64'd0,
           de: RNONE, dm: RNONE};
    for (int i = 0; i < 15; i++) mregs[i] = 64'd0;
    mret = 64'd0;
  endfunction

  function automatic logic [63:0] model_read(input logic [3:0] id);
    if (id == RNONE) return 64'd0;
    return mregs[id];
  endfunction

  // Retire the instruction sitting in W, then move the pipeline.
  function automatic void model_edge();
    bit retires_ok;
    retires_ok = mw.valid && (mw.stat == SAOK);
    if (retires_ok) begin
      if (mw.de != RNONE) mregs[mw.de] = mw.ve;
      if (mw.dm != RNONE) mregs[mw.dm] = mw.vm;
    end
    if (retires_ok || (mw.valid && mw.stat == SHLT)) mret = mret + 64'd1;
    if (!stall) begin
      if (bubble)
        mw = '{icode: INOP, stat: SAOK, valid: 1'b0, ve: 64'd0, vm: 64'd0,
               de: RNONE, dm: RNONE};
      else
        mw = '{icode: m_icode, stat: m_stat, valid: m_valid, ve: m_vale,
               vm: m_valm, de: m_dste, dm: m_dstm};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_m(input logic v, input logic [3:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
    m_valid = v; m_stat = st; m_icode = ic;
    m_vale = ve; m_valm = vm; m_dste = de; m_dstm = dm;
  endtask

  task automatic drive_nop();
    drive_m(1'b0, SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE);
  endtask

  // One rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; bubble = 1'b0;
    src_a = 4'd0; src_b = RNONE;
    drive_nop();
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      src_a = 4'(i);
      #1;
      n_vec++;
      if (rval_a !== 64'd0) begin
        n_err++;
        $display("FAIL reset_read src=%0d got=%h exp=0", i, rval_a);
      end
    end
    n_vec++;
    if (stat !== SAOK) begin n_err++; $display("FAIL reset_stat got=%h exp=%h", stat, SAOK); end
    n_vec++;
    if (retired !== 64'd0) begin n_err++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    n_vec++;
    if (w_icode !== INOP || w_dste !== RNONE || w_dstm !== RNONE) begin
      n_err++;
      $display("FAIL reset_w icode=%h dstE=%h dstM=%h exp=%h/F/F", w_icode, w_dste, w_dstm, INOP);
    end
  endtask

  task automatic test_single_write();
    drive_m(1'b1, SAOK, IOPQ, 64'h1234, 64'd0, 4'd3, RNONE);
    tick();
    n_vec++;
    if (w_vale !== 64'h1234 || w_dste !== 4'd3) begin
      n_err++;
      $display("FAIL w_latch valE=%h dstE=%h exp=1234/3", w_vale, w_dste);
    end
    drive_nop();
    src_a = 4'd3;
    #1;
    // The write is still pending in W; the read port has no bypass.
    n_vec++;
    if (rval_a !== 64'd0) begin n_err++; $display("FAIL no_bypass got=%h exp=0", rval_a); end
    tick();
    n_vec++;
    if (rval_a !== 64'h1234) begin n_err++; $display("FAIL wb_visible got=%h exp=1234", rval_a); end
    n_vec++;
    if (retired !== 64'd1) begin n_err++; $display("FAIL retire_one got=%0d exp=1", retired); end
  endtask

  task automatic test_same_dst();
    drive_m(1'b1, SAOK, IPOPQ, 64'd8, 64'hAA, 4'd4, 4'd4);
    tick();
    drive_nop();
    src_a = 4'd4;
    tick();
    n_vec++;
    if (rval_a !== 64'hAA) begin n_err++; $display("FAIL valm_wins got=%h exp=aa", rval_a); end
    n_vec++;
    if (retired !== 64'd2) begin n_err++; $display("FAIL retire_two got=%0d exp=2", retired); end
  endtask

  task automatic test_stall_exception();
    drive_m(1'b1, SADR, IOPQ, 64'hDEAD, 64'd0, 4'd2, RNONE);
    tick();
    drive_m(1'b1, SAOK, IOPQ, 64'h5555, 64'd0, 4'd2, RNONE);
    stall = 1'b1;
    src_b = 4'd2;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (stat !== SADR) begin n_err++; $display("FAIL stall_stat edge=%0d got=%h exp=%h", k, stat, SADR); end
      n_vec++;
      if (rval_b !== 64'd0) begin n_err++; $display("FAIL stall_nowrite edge=%0d got=%h exp=0", k, rval_b); end
      n_vec++;
      if (retired !== 64'd2) begin n_err++; $display("FAIL stall_retired edge=%0d got=%0d exp=2", k, retired); end
      n_vec++;
      if (w_dste !== 4'd2 || w_vale !== 64'hDEAD) begin
        n_err++;
        $display("FAIL stall_hold edge=%0d dstE=%h valE=%h exp=2/dead", k, w_dste, w_vale);
      end
    end
    stall = 1'b0;
    bubble = 1'b1;
    tick();
    bubble = 1'b0;
    n_vec++;
    if (stat !== SAOK) begin n_err++; $display("FAIL stat_recover got=%h exp=%h", stat, SAOK); end
  endtask

  task automatic test_bubble();
    drive_m(1'b1, SAOK, IOPQ, 64'h77, 64'd0, 4'd6, RNONE);
    bubble = 1'b1;
    tick();
    n_vec++;
    if (w_dste !== RNONE || w_icode !== INOP) begin
      n_err++;
      $display("FAIL bubble_load dstE=%h icode=%h exp=F/%h", w_dste, w_icode, INOP);
    end
    bubble = 1'b0;
    drive_nop();
    src_a = 4'd6;
    tick();
    n_vec++;
    if (rval_a !== 64'd0) begin n_err++; $display("FAIL bubble_nowrite got=%h exp=0", rval_a); end
    drive_m(1'b1, SAOK, IOPQ, 64'h99, 64'd0, 4'd6, RNONE);
    tick();
    // Stall and bubble together: W holds, but its AOK instruction still writes.
    drive_m(1'b1, SAOK, IOPQ, 64'h42, 64'd0, 4'd7, RNONE);
    stall = 1'b1;
    bubble = 1'b1;
    tick();
    n_vec++;
    if (w_dste !== 4'd6 || w_vale !== 64'h99) begin
      n_err++;
      $display("FAIL stall_over_bubble dstE=%h valE=%h exp=6/99", w_dste, w_vale);
    end
    n_vec++;
    if (rval_a !== 64'h99) begin n_err++; $display("FAIL stalled_aok_write got=%h exp=99", rval_a); end
    n_vec++;
    if (retired !== mret) begin n_err++; $display("FAIL bubble_retired got=%0d exp=%0d", retired, mret); end
    stall = 1'b0;
    tick();
    bubble = 1'b0;
    drive_nop();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall  = ($urandom_range(0, 9) == 0);
      bubble = ($urandom_range(0, 9) == 0);
      drive_m(($urandom_range(0, 4) != 0),
              ($urandom_range(0, 5) != 0) ? SAOK : 4'($urandom_range(2, 4)),
              4'($urandom_range(0, 11)),
              {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      src_a = 4'($urandom_range(0, 15));
      src_b = 4'($urandom_range(0, 15));
      tick();
      n_vec++;
      if (rval_a !== model_read(src_a)) begin
        n_err++; $display("FAIL rnd_rvalA n=%0d src=%h got=%h exp=%h", n, src_a, rval_a, model_read(src_a));
      end
      n_vec++;
      if (rval_b !== model_read(src_b)) begin
        n_err++; $display("FAIL rnd_rvalB n=%0d src=%h got=%h exp=%h", n, src_b, rval_b, model_read(src_b));
      end
      n_vec++;
      if (w_icode !== mw.icode || w_dste !== mw.de || w_dstm !== mw.dm) begin
        n_err++;
        $display("FAIL rnd_wctl n=%0d icode=%h dstE=%h dstM=%h exp=%h/%h/%h",
                 n, w_icode, w_dste, w_dstm, mw.icode, mw.de, mw.dm);
      end
      n_vec++;
      if (w_vale !== mw.ve || w_valm !== mw.vm) begin
        n_err++; $display("FAIL rnd_wval n=%0d valE=%h valM=%h exp=%h/%h", n, w_vale, w_valm, mw.ve, mw.vm);
      end
      n_vec++;
      if (stat !== mw.stat) begin n_err++; $display("FAIL rnd_stat n=%0d got=%h exp=%h", n, stat, mw.stat); end
      n_vec++;
      if (retired !== mret) begin n_err++; $display("FAIL rnd_retired n=%0d got=%0d exp=%0d", n, retired, mret); end
    end
    stall = 1'b0;
    bubble = 1'b0;
    drive_nop();
    tick();
  endtask

  task automatic test_async_reset();
    drive_m(1'b1, SAOK, IOPQ, 64'hCAFE, 64'd0, 4'd5, RNONE);
    tick();
    drive_m(1'b1, SAOK, IOPQ, 64'hBEEF, 64'd0, 4'd8, RNONE);
    src_a = 4'd5;
    tick();
    n_vec++;
    if (rval_a !== 64'hCAFE) begin n_err++; $display("FAIL pre_reset_write got=%h exp=cafe", rval_a); end
    // W now holds the reg 8 write; reset lands between edges.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (rval_a !== 64'd0) begin n_err++; $display("FAIL async_clear_reg got=%h exp=0", rval_a); end
    n_vec++;
    if (w_dste !== RNONE || w_icode !== INOP || w_vale !== 64'd0) begin
      n_err++;
      $display("FAIL async_clear_w dstE=%h icode=%h valE=%h exp=F/%h/0", w_dste, w_icode, w_vale, INOP);
    end
    n_vec++;
    if (retired !== 64'd0) begin n_err++; $display("FAIL async_clear_retired got=%0d exp=0", retired); end
    drive_nop();
    @(posedge clk);
    #2 rst_n = 1'b1;
    src_b = 4'd8;
    tick();
    n_vec++;
    if (rval_b !== 64'd0) begin n_err++; $display("FAIL no_partial_write got=%h exp=0", rval_b); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_write();
    test_same_dst();
    test_stall_exception();
    test_bubble();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
